// File: rtl/core_pkg.sv
// Shared core definitions: default control-bundle widths, NOP encodings
// and the default performance-counter width and saturation value.
package core_pkg;

    localparam int WB_W_DEF = 2;
    localparam int M_W_DEF  = 5;
    localparam int EX_W_DEF = 6;

    localparam logic [WB_W_DEF-1:0] NOP_WB = '0;
    localparam logic [M_W_DEF-1:0]  NOP_M  = '0;
    localparam logic [EX_W_DEF-1:0] NOP_EX = '0;

    localparam int                   CNT_W_DEF   = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT = '1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != SAT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/idex_ctrl_pipe.sv
// ID/EX control pipeline register: bubble insertion on stall/flush, freeze on
// EX hold with deferred flush, plus bubble counter and stall watchdog.
module idex_ctrl_pipe
    import core_pkg::*;
#(
    parameter int              WB_W        = WB_W_DEF,
    parameter int              M_W         = M_W_DEF,
    parameter int              EX_W        = EX_W_DEF,
    parameter logic [WB_W-1:0] BUBBLE_WB   = WB_W'(NOP_WB),
    parameter logic [M_W-1:0]  BUBBLE_M    = M_W'(NOP_M),
    parameter logic [EX_W-1:0] BUBBLE_EX   = EX_W'(NOP_EX),
    parameter int              CNT_W       = CNT_W_DEF,
    parameter int              STALL_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [WB_W-1:0]  cntrl_wb,
    input  logic [M_W-1:0]   cntrl_m,
    input  logic [EX_W-1:0]  cntrl_ex,
    input  logic             stall,
    input  logic             id_flush,
    input  logic             ex_hold,
    input  logic             clr_stats,
    output logic [WB_W-1:0]  idex_wb,
    output logic [M_W-1:0]   idex_m,
    output logic [EX_W-1:0]  idex_ex,
    output logic             idex_valid,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             stall_timeout
);

    localparam int              RUN_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_LIMIT);

    logic [WB_W-1:0]  wb_q, wb_d;
    logic [M_W-1:0]   m_q, m_d;
    logic [EX_W-1:0]  ex_q, ex_d;
    logic             vld_q, vld_d;
    logic             flush_pend_q, flush_pend_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    logic bubble_ld, normal_ld, bubble_evt, run_inc;

    assign bubble_ld  = !ex_hold && (id_flush || flush_pend_q || stall);
    assign normal_ld  = !ex_hold && !bubble_ld;
    assign bubble_evt = bubble_ld || (normal_ld && !id_valid);
    assign run_inc    = stall || ex_hold;

    always_comb begin
        wb_d         = wb_q;
        m_d          = m_q;
        ex_d         = ex_q;
        vld_d        = vld_q;
        flush_pend_d = flush_pend_q;
        if (ex_hold) begin
            // A flush seen while frozen must still kill the ID instruction later.
            if (id_flush) flush_pend_d = 1'b1;
        end else if (bubble_ld) begin
            wb_d         = BUBBLE_WB;
            m_d          = BUBBLE_M;
            ex_d         = BUBBLE_EX;
            vld_d        = 1'b0;
            flush_pend_d = 1'b0;
        end else begin
            wb_d  = cntrl_wb;
            m_d   = cntrl_m;
            ex_d  = cntrl_ex;
            vld_d = id_valid;
        end
    end

    always_comb begin
        run_d = '0;
        if (run_inc)
            run_d = (run_q == RUN_LIM) ? RUN_LIM : run_q + 1'b1;
        timeout_d = timeout_q || (run_inc && run_d == RUN_LIM);
        if (clr_stats) timeout_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q         <= BUBBLE_WB;
            m_q          <= BUBBLE_M;
            ex_q         <= BUBBLE_EX;
            vld_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            run_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            m_q          <= m_d;
            ex_q         <= ex_d;
            vld_q        <= vld_d;
            flush_pend_q <= flush_pend_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_evt),
        .clr   (clr_stats),
        .cnt   (bubble_cnt)
    );

    assign idex_wb       = wb_q;
    assign idex_m        = m_q;
    assign idex_ex       = ex_q;
    assign idex_valid    = vld_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// Bench for idex_ctrl_pipe: directed plan steps then random traffic, checked
// against a rule-level reference model; two instances cover counter widths.
module tb_idex_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, stall, id_flush, ex_hold, clr_stats;
    logic [1:0] cntrl_wb;
    logic [4:0] cntrl_m;
    logic [5:0] cntrl_ex;

    logic [1:0]  a_wb, b_wb;
    logic [4:0]  a_m, b_m;
    logic [5:0]  a_ex, b_ex;
    logic        a_v, b_v, a_to, b_to;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [1:0] e_wb;
    logic [4:0] e_m;
    logic [5:0] e_ex;
    logic       e_v, e_pend, e_to;
    int         e_run, e_bub;

    always #5 clk = ~clk;

    idex_ctrl_pipe #(.CNT_W(16), .STALL_LIMIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .cntrl_wb(cntrl_wb),
        .cntrl_m(cntrl_m), .cntrl_ex(cntrl_ex), .stall(stall), .id_flush(id_flush),
        .ex_hold(ex_hold), .clr_stats(clr_stats), .idex_wb(a_wb), .idex_m(a_m),
        .idex_ex(a_ex), .idex_valid(a_v), .bubble_cnt(a_cnt), .stall_timeout(a_to)
    );

    idex_ctrl_pipe #(.CNT_W(2), .STALL_LIMIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .cntrl_wb(cntrl_wb),
        .cntrl_m(cntrl_m), .cntrl_ex(cntrl_ex), .stall(stall), .id_flush(id_flush),
        .ex_hold(ex_hold), .clr_stats(clr_stats), .idex_wb(b_wb), .idex_m(b_m),
        .idex_ex(b_ex), .idex_valid(b_v), .bubble_cnt(b_cnt), .stall_timeout(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_wb = '0; e_m = '0; e_ex = '0; e_v = 1'b0;
        e_pend = 1'b0; e_to = 1'b0; e_run = 0; e_bub = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " wb"},    32'(a_wb),  32'(e_wb));
        chk({tag, " m"},     32'(a_m),   32'(e_m));
        chk({tag, " ex"},    32'(a_ex),  32'(e_ex));
        chk({tag, " valid"}, 32'(a_v),   32'(e_v));
        chk({tag, " cntA"},  32'(a_cnt), (e_bub > 65535) ? 32'd65535 : 32'(e_bub));
        chk({tag, " toA"},   32'(a_to),  32'(e_to));
        chk({tag, " b_ctl"}, {19'd0, b_v, b_wb, b_m, b_ex}, {19'd0, e_v, e_wb, e_m, e_ex});
        chk({tag, " cntB"},  32'(b_cnt), (e_bub > 3) ? 32'd3 : 32'(e_bub));
        chk({tag, " toB"},   32'(b_to),  32'(e_to));
    endtask

    // One clock: drive inputs, apply the per-edge rules to the model, check.
    task automatic step(input string tag, input logic st, input logic fl, input logic hd,
                        input logic vl, input logic cs, input logic [1:0] wb,
                        input logic [4:0] m, input logic [5:0] ex);
        stall = st; id_flush = fl; ex_hold = hd; id_valid = vl; clr_stats = cs;
        cntrl_wb = wb; cntrl_m = m; cntrl_ex = ex;
        @(posedge clk);
        if (hd) begin
            if (fl) e_pend = 1'b1;
        end else if (fl || e_pend || st) begin
            e_wb = '0; e_m = '0; e_ex = '0; e_v = 1'b0;
            e_pend = 1'b0;
            e_bub++;
        end else begin
            e_wb = wb; e_m = m; e_ex = ex; e_v = vl;
            if (!vl) e_bub++;
        end
        e_run = (st || hd) ? e_run + 1 : 0;
        if (e_run >= 4) e_to = 1'b1;
        if (cs) begin e_bub = 0; e_to = 1'b0; end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; id_flush = 0; ex_hold = 0; id_valid = 0; clr_stats = 0;
        cntrl_wb = '0; cntrl_m = '0; cntrl_ex = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("load",  0, 0, 0, 1, 0, 2'b11, 5'h15, 6'h2A);
        step("stall", 1, 0, 0, 1, 0, 2'b01, 5'h0A, 6'h15);
        step("reld",  0, 0, 0, 1, 0, 2'b01, 5'h0A, 6'h15);

        step("hold1", 0, 0, 1, 1, 0, 2'b10, 5'h11, 6'h22);
        step("hold2", 0, 1, 1, 1, 0, 2'b10, 5'h11, 6'h22);
        step("hold3", 0, 0, 1, 1, 0, 2'b10, 5'h11, 6'h22);
        step("dflsh", 0, 0, 0, 1, 0, 2'b10, 5'h11, 6'h22);
        chk("dflsh cnt", 32'(a_cnt), 32'd2);

        step("pre_sf", 0, 0, 0, 1, 0, 2'b11, 5'h1F, 6'h3F);
        step("st_fl",  1, 1, 0, 1, 0, 2'b11, 5'h1F, 6'h3F);
        chk("st_fl cnt", 32'(a_cnt), 32'd3);

        step("wd_pre", 0, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        step("wd1",    1, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        step("wd2",    1, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        step("wd3",    1, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        chk("wd3 flag", 32'(a_to), 32'd0);
        step("wd4",    1, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        chk("wd4 flag", 32'(a_to), 32'd1);
        step("wd_drop", 0, 0, 0, 1, 0, 2'b01, 5'h03, 6'h05);
        step("clr",     0, 0, 0, 1, 1, 2'b01, 5'h03, 6'h05);
        chk("clr flag", 32'(a_to), 32'd0);
        chk("clr cnt",  32'(a_cnt), 32'd0);

        for (int i = 0; i < 5; i++)
            step("sat", 1, 0, 0, 1, 0, 2'b10, 5'h07, 6'h09);
        chk("sat cntB", 32'(b_cnt), 32'd3);
        chk("sat cntA", 32'(a_cnt), 32'd5);

        // async reset between edges while a flush is pending under hold
        step("rh_ld",   0, 0, 0, 1, 0, 2'b11, 5'h15, 6'h2A);
        step("rh_hold", 0, 1, 1, 1, 0, 2'b11, 5'h15, 6'h2A);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("areset");
        ex_hold = 0; id_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 1, 0, 2'b11, 5'h15, 6'h2A);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(3) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0), 2'($urandom), 5'($urandom), 6'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
